// File: rtl/ptc_input_cond.sv
// ptc_input_cond
// Conditions the PTC external clock/gate and capture pads for the timer core.
// Each pad passes through a 2-flop synchroniser and a glitch filter, then an
// edge detector. The outputs are registered capture strobes, a clean capture
// level, a prescaled count-enable tick and the polarity-adjusted gate level.
module ptc_input_cond #(
  parameter int FILT_W = 4,
  parameter int PRE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ecgt_i,
  input  logic              capt_i,
  input  logic              en_i,
  input  logic              nec_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [PRE_W-1:0]  presc_i,
  output logic              ecgt_gate_o,
  output logic              cnt_tick_o,
  output logic              capt_lvl_o,
  output logic              capt_rise_o,
  output logic              capt_fall_o
);

  // Channel 0 is the external clock/gate pad, channel 1 is the capture pad.
  localparam int CH_ECGT = 0;
  localparam int CH_CAPT = 1;
  localparam logic [FILT_W-1:0] FCNT_MAX = '1;

  logic [1:0]        pad;
  logic [1:0]        sync1;
  logic [1:0]        sync2;
  logic [1:0]        lvl;
  logic [1:0]        lvl_d;
  logic [FILT_W-1:0] fcnt [2];
  logic [1:0]        rise;
  logic [1:0]        fall;
  logic              qual_edge;
  logic [PRE_W-1:0]  pcnt;

  assign pad = {capt_i, ecgt_i};

  // Two-flop synchroniser per pad.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
    end
  end

  // Glitch filter: a new level is accepted only after filt_len_i+1 consecutive
  // mismatching samples. The counter saturates so that lowering filt_len_i
  // below a running count cannot make it wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        fcnt[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2[ch] == lvl[ch]) begin
          fcnt[ch] <= '0;
        end else if (fcnt[ch] == filt_len_i) begin
          lvl[ch]  <= sync2[ch];
          fcnt[ch] <= '0;
        end else if (fcnt[ch] != FCNT_MAX) begin
          fcnt[ch] <= fcnt[ch] + 1'b1;
        end
      end
    end
  end

  // Delayed filtered levels for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_d <= '0;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

  // The qualified edge comes from the raw filtered level, so flipping nec_i
  // only changes which edge is selected and never fabricates one.
  assign qual_edge = nec_i ? fall[CH_ECGT] : rise[CH_ECGT];

  // Registered capture strobes, one cycle after the filtered level moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      capt_rise_o <= 1'b0;
      capt_fall_o <= 1'b0;
    end else begin
      capt_rise_o <= rise[CH_CAPT];
      capt_fall_o <= fall[CH_CAPT];
    end
  end

  // Prescaler: one tick per presc_i+1 qualified edges. The >= compare makes a
  // lowered presc_i take effect on the very next edge instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      cnt_tick_o <= 1'b0;
    end else if (!en_i) begin
      pcnt       <= '0;
      cnt_tick_o <= 1'b0;
    end else if (qual_edge) begin
      if (pcnt >= presc_i) begin
        pcnt       <= '0;
        cnt_tick_o <= 1'b1;
      end else begin
        pcnt       <= pcnt + 1'b1;
        cnt_tick_o <= 1'b0;
      end
    end else begin
      cnt_tick_o <= 1'b0;
    end
  end

  assign capt_lvl_o  = lvl[CH_CAPT];
  assign ecgt_gate_o = lvl[CH_ECGT] ^ nec_i;

endmodule

// File: tb/tb_ptc_input_cond.sv
// tb_ptc_input_cond
// Directed stimulus for ptc_input_cond. A sample-window model predicts every
// output each cycle; literal edge-number expectations pin the model latency.
module tb_ptc_input_cond;

  localparam int FILT_W = 4;
  localparam int PRE_W  = 8;
  localparam int WIN_MAX = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ecgt_i = 1'b0;
  logic              capt_i = 1'b0;
  logic              en_i = 1'b0;
  logic              nec_i = 1'b0;
  logic [FILT_W-1:0] filt_len_i = '0;
  logic [PRE_W-1:0]  presc_i = '0;
  logic              ecgt_gate_o;
  logic              cnt_tick_o;
  logic              capt_lvl_o;
  logic              capt_rise_o;
  logic              capt_fall_o;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int n_tick = 0;
  int n_rise = 0;
  int n_fall = 0;
  int last_tick = -1;
  int last_rise = -1;
  int last_fall = -1;

  ptc_input_cond #(.FILT_W(FILT_W), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ecgt_i      (ecgt_i),
    .capt_i      (capt_i),
    .en_i        (en_i),
    .nec_i       (nec_i),
    .filt_len_i  (filt_len_i),
    .presc_i     (presc_i),
    .ecgt_gate_o (ecgt_gate_o),
    .cnt_tick_o  (cnt_tick_o),
    .capt_lvl_o  (capt_lvl_o),
    .capt_rise_o (capt_rise_o),
    .capt_fall_o (capt_fall_o)
  );

  always #5 clk = ~clk;

  // Edge numbering used by the literal expectations.
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- behavioural model ----------------
  bit m_dly_e[$];
  bit m_dly_c[$];
  bit m_win_e[$];
  bit m_win_c[$];
  bit m_cur_e, m_cur_c, m_prev_e, m_prev_c;
  int m_since;
  bit exp_tick, exp_rise, exp_fall;

  // True when the newest len+1 synchronised samples all disagree with cur.
  function automatic bit accepted(input bit win[$], input bit cur, input int len);
    if (win.size() < len + 1) return 1'b0;
    for (int i = win.size() - len - 1; i < win.size(); i++)
      if (win[i] == cur) return 1'b0;
    return 1'b1;
  endfunction

  // Model update on each clock edge, from the inputs the DUT samples there.
  always @(posedge clk) begin
    bit qe;
    bit seen_e;
    bit seen_c;
    if (rst) begin
      m_dly_e = {};
      m_dly_c = {};
      m_dly_e.push_back(1'b0); m_dly_e.push_back(1'b0);
      m_dly_c.push_back(1'b0); m_dly_c.push_back(1'b0);
      m_win_e = {};
      m_win_c = {};
      m_cur_e = 1'b0; m_cur_c = 1'b0; m_prev_e = 1'b0; m_prev_c = 1'b0;
      m_since = 0;
      exp_tick = 1'b0; exp_rise = 1'b0; exp_fall = 1'b0;
    end else begin
      qe = nec_i ? (!m_cur_e && m_prev_e) : (m_cur_e && !m_prev_e);
      exp_rise = m_cur_c && !m_prev_c;
      exp_fall = !m_cur_c && m_prev_c;
      exp_tick = 1'b0;
      if (!en_i) begin
        m_since = 0;
      end else if (qe) begin
        m_since++;
        if (m_since >= int'(presc_i) + 1) begin
          exp_tick = 1'b1;
          m_since = 0;
        end
      end
      m_prev_e = m_cur_e;
      m_prev_c = m_cur_c;
      m_dly_e.push_back(ecgt_i);
      m_dly_c.push_back(capt_i);
      seen_e = m_dly_e.pop_front();
      seen_c = m_dly_c.pop_front();
      m_win_e.push_back(seen_e);
      m_win_c.push_back(seen_c);
      if (m_win_e.size() > WIN_MAX) void'(m_win_e.pop_front());
      if (m_win_c.size() > WIN_MAX) void'(m_win_c.pop_front());
      if (accepted(m_win_e, m_cur_e, int'(filt_len_i))) m_cur_e = seen_e;
      if (accepted(m_win_c, m_cur_c, int'(filt_len_i))) m_cur_c = seen_c;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, edge_n, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic compare_outputs();
    check("cnt_tick_o", cnt_tick_o, exp_tick);
    check("capt_rise_o", capt_rise_o, exp_rise);
    check("capt_fall_o", capt_fall_o, exp_fall);
    check("capt_lvl_o", capt_lvl_o, m_cur_c);
    check("ecgt_gate_o", ecgt_gate_o, m_cur_e ^ nec_i);
    if (cnt_tick_o === 1'b1)  begin n_tick++; last_tick = edge_n; end
    if (capt_rise_o === 1'b1) begin n_rise++; last_rise = edge_n; end
    if (capt_fall_o === 1'b1) begin n_fall++; last_fall = edge_n; end
  endtask

  // Advance n cycles, checking at each falling edge; inputs change 1 ns later.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_outputs();
      #1;
    end
  endtask

  task automatic pulse_ecgt(output int k_rise, output int k_fall);
    ecgt_i = 1'b1;
    k_rise = edge_n + 1;
    step(8);
    ecgt_i = 1'b0;
    k_fall = edge_n + 1;
    step(8);
  endtask

  initial begin
    int k, kf, t0, r0, f0, r;

    // Reset state
    step(2);
    check("rst cnt_tick_o", cnt_tick_o, 1'b0);
    check("rst capt_rise_o", capt_rise_o, 1'b0);
    check("rst capt_fall_o", capt_fall_o, 1'b0);
    check("rst capt_lvl_o", capt_lvl_o, 1'b0);
    check("rst ecgt_gate_o", ecgt_gate_o, 1'b0);
    rst = 1'b0;
    en_i = 1'b1;
    step(5);

    // filt 0, presc 0: tick exactly 3 edges after the pad is first sampled
    t0 = n_tick;
    ecgt_i = 1'b1;
    k = edge_n + 1;
    step(8);
    check_int("t1 tick count", n_tick - t0, 1);
    check_int("t1 tick edge", last_tick, k + 3);
    check("t1 gate level", ecgt_gate_o, 1'b1);
    ecgt_i = 1'b0;
    step(8);
    check_int("t1 no tick on fall", n_tick - t0, 1);

    // filt 3: short glitch dropped, long pulse passes with k+6 latency
    filt_len_i = 4'd3;
    step(2);
    r0 = n_rise;
    f0 = n_fall;
    capt_i = 1'b1;
    step(3);
    capt_i = 1'b0;
    step(15);
    check_int("t2 glitch dropped", n_rise - r0, 0);
    capt_i = 1'b1;
    k = edge_n + 1;
    step(10);
    check_int("t2 rise edge", last_rise, k + 6);
    check("t2 capt level", capt_lvl_o, 1'b1);
    capt_i = 1'b0;
    k = edge_n + 1;
    step(12);
    check_int("t2 fall edge", last_fall, k + 6);
    check_int("t2 rise count", n_rise - r0, 1);
    check_int("t2 fall count", n_fall - f0, 1);

    // presc 4: 20 rising edges -> ticks on edges 5, 10, 15, 20
    filt_len_i = 4'd0;
    presc_i = 8'd4;
    step(2);
    t0 = n_tick;
    for (int i = 1; i <= 20; i++) begin
      pulse_ecgt(k, kf);
      if (i % 5 == 0)
        check_int($sformatf("t3 tick on edge %0d", i), last_tick, k + 3);
    end
    check_int("t3 tick count", n_tick - t0, 4);

    // en_i low clears a partial prescale count
    for (int i = 0; i < 3; i++) pulse_ecgt(k, kf);
    en_i = 1'b0;
    step(3);
    en_i = 1'b1;
    step(1);
    t0 = n_tick;
    for (int i = 0; i < 4; i++) pulse_ecgt(k, kf);
    check_int("t3 cleared no tick", n_tick - t0, 0);
    pulse_ecgt(k, kf);
    check_int("t3 cleared tick edge", last_tick, k + 3);
    check_int("t3 cleared tick count", n_tick - t0, 1);

    // nec_i: inversion of gate, no tick from toggling, ticks on falling edges
    presc_i = 8'd0;
    t0 = n_tick;
    nec_i = 1'b1;
    step(1);
    check("t4 gate inverted", ecgt_gate_o, 1'b1);
    step(4);
    check_int("t4 toggle no tick", n_tick - t0, 0);
    for (int i = 0; i < 3; i++) pulse_ecgt(k, kf);
    check_int("t4 fall tick edge", last_tick, kf + 3);
    check_int("t4 fall tick count", n_tick - t0, 3);
    nec_i = 1'b0;
    step(4);
    check("t4 gate restored", ecgt_gate_o, 1'b0);
    check_int("t4 restore no tick", n_tick - t0, 3);

    // presc 7 -> 1 with five edges counted
    presc_i = 8'd7;
    t0 = n_tick;
    for (int i = 0; i < 5; i++) pulse_ecgt(k, kf);
    check_int("t5 no tick at 5", n_tick - t0, 0);
    presc_i = 8'd1;
    pulse_ecgt(k, kf);
    check_int("t5 wrap tick edge", last_tick, k + 3);
    pulse_ecgt(k, kf);
    check_int("t5 one after wrap", n_tick - t0, 1);
    pulse_ecgt(k, kf);
    check_int("t5 second tick edge", last_tick, k + 3);
    check_int("t5 tick count", n_tick - t0, 2);

    // reset mid-filter and mid-prescale, pads held high through release
    filt_len_i = 4'd5;
    presc_i = 8'd3;
    for (int i = 0; i < 2; i++) pulse_ecgt(k, kf);
    capt_i = 1'b1;
    ecgt_i = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    r = edge_n;
    check("t6 rst cnt_tick_o", cnt_tick_o, 1'b0);
    check("t6 rst capt_rise_o", capt_rise_o, 1'b0);
    check("t6 rst capt_fall_o", capt_fall_o, 1'b0);
    check("t6 rst capt_lvl_o", capt_lvl_o, 1'b0);
    check("t6 rst ecgt_gate_o", ecgt_gate_o, 1'b0);
    rst = 1'b0;
    t0 = n_tick;
    step(15);
    check_int("t6 rise after release", last_rise, r + 9);
    check_int("t6 no tick after reset", n_tick - t0, 0);
    capt_i = 1'b0;
    ecgt_i = 1'b0;
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
